// File: rtl/escape_sequence_decoder_pkg.sv
// Package: escape_sequence_decoder_pkg
// Command types and the parameter record shared between the escape sequence
// decoder and every block that consumes its command stream.
package escape_sequence_decoder_pkg;

    // INPUT is encoded as zero, so a cleared command register reads as INPUT.
    typedef enum logic [2:0] {
        INPUT = 3'd0,
        HTS   = 3'd1,
        TBC   = 3'd2,
        CHT   = 3'd3,
        CBT   = 3'd4
    } CommandsType;

    // Pn1: numeric parameter (zero for INPUT).
    // Pchar: received character (zero for everything except INPUT).
    typedef struct packed {
        logic [7:0] Pn1;
        logic [7:0] Pchar;
    } Param_t;

endpackage

// File: rtl/escape_sequence_decoder.sv
// Module: escape_sequence_decoder
// Turns the received host byte stream into commands. Ground-state characters
// become INPUT commands. ESC / CSI sequences decode to HTS, TBC, CHT and CBT.
// Any other sequence is consumed without producing a command.
//
// Ports
//   clk           system clock
//   rst_n         synchronous reset, active low
//   dataValid     dataIn carries a byte this cycle (no backpressure)
//   dataIn        received character
//   commandReady  one-cycle strobe: commandType / param are valid
//   commandType   INPUT, HTS, TBC, CHT or CBT; holds until the next command
//   param         Pn1 numeric parameter, Pchar character; holds until the next command
//   parserIdle    high while the decoder is in the ground state
module escape_sequence_decoder
    import escape_sequence_decoder_pkg::*;
#(
    parameter logic [7:0] PARAM_MAX = 8'd255,
    parameter bit         C1_CSI    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dataValid,
    input  logic [7:0]  dataIn,
    output logic        commandReady,
    output CommandsType commandType,
    output Param_t      param,
    output logic        parserIdle
);

    typedef enum logic [1:0] {
        S_GROUND,
        S_ESC,
        S_CSI_PARAM,
        S_CSI_IGNORE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  acc, acc_n;
    logic        semi, semi_n;
    logic        ready_n;
    CommandsType type_n;
    Param_t      param_n;

    logic        is_exec;
    logic        is_print;
    logic        is_digit;
    logic        is_final;
    logic        is_inter;
    logic [11:0] acc_mul;
    logic [7:0]  acc_nz;

    // Byte classes used by several states.
    assign is_exec  = (dataIn == 8'h08) || (dataIn == 8'h09) ||
                      (dataIn == 8'h0A) || (dataIn == 8'h0D);
    assign is_print = (dataIn >= 8'h20) && (dataIn <= 8'h7E);
    assign is_digit = (dataIn >= 8'h30) && (dataIn <= 8'h39);
    assign is_final = (dataIn >= 8'h40) && (dataIn <= 8'h7E);
    assign is_inter = (dataIn >= 8'h20) && (dataIn <= 8'h3F);

    // Accumulator step at 12 bits: 255*10+9 still fits, so the saturation compare is exact.
    assign acc_mul = {4'b0, acc} * 12'd10 + {8'b0, dataIn[3:0]};
    // CHT / CBT treat an empty or zero parameter as one.
    assign acc_nz  = (acc == 8'd0) ? 8'd1 : acc;

    assign parserIdle = (state == S_GROUND);

    // NOTE: every variable this block writes gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        semi_n  = semi;
        ready_n = 1'b0;
        type_n  = commandType;
        param_n = param;

        if (dataValid) begin
            if ((dataIn == 8'h18) || (dataIn == 8'h1A)) begin
                state_n = S_GROUND;
            end else if (dataIn == 8'h1B) begin
                state_n = S_ESC;
                acc_n   = 8'd0;
                semi_n  = 1'b0;
            end else if (dataIn == 8'h7F) begin
                // DEL is padding in every state.
            end else begin
                case (state)
                    S_GROUND: begin
                        if (is_print || is_exec) begin
                            ready_n = 1'b1;
                            type_n  = INPUT;
                            param_n = '{Pn1: 8'd0, Pchar: dataIn};
                        end else if (C1_CSI && (dataIn == 8'h9B)) begin
                            state_n = S_CSI_PARAM;
                            acc_n   = 8'd0;
                            semi_n  = 1'b0;
                        end
                    end

                    S_ESC: begin
                        if (dataIn == 8'h48) begin
                            ready_n = 1'b1;
                            type_n  = HTS;
                            param_n = '0;
                            state_n = S_GROUND;
                        end else if (dataIn == 8'h5B) begin
                            state_n = S_CSI_PARAM;
                            acc_n   = 8'd0;
                            semi_n  = 1'b0;
                        end else begin
                            state_n = S_GROUND;
                        end
                    end

                    S_CSI_PARAM: begin
                        if (is_digit) begin
                            // Only the first parameter is kept; digits after ';' are dropped.
                            if (!semi) begin
                                acc_n = (acc_mul > {4'b0, PARAM_MAX}) ? PARAM_MAX : acc_mul[7:0];
                            end
                        end else if (dataIn == 8'h3B) begin
                            semi_n = 1'b1;
                        end else if (is_exec) begin
                            ready_n = 1'b1;
                            type_n  = INPUT;
                            param_n = '{Pn1: 8'd0, Pchar: dataIn};
                        end else if (is_inter) begin
                            state_n = S_CSI_IGNORE;
                        end else if (is_final) begin
                            state_n = S_GROUND;
                            case (dataIn)
                                8'h67: begin
                                    ready_n = 1'b1;
                                    type_n  = TBC;
                                    param_n = '{Pn1: acc, Pchar: 8'd0};
                                end
                                8'h49: begin
                                    ready_n = 1'b1;
                                    type_n  = CHT;
                                    param_n = '{Pn1: acc_nz, Pchar: 8'd0};
                                end
                                8'h5A: begin
                                    ready_n = 1'b1;
                                    type_n  = CBT;
                                    param_n = '{Pn1: acc_nz, Pchar: 8'd0};
                                end
                                default: ;
                            endcase
                        end
                    end

                    S_CSI_IGNORE: begin
                        if (is_final) begin
                            state_n = S_GROUND;
                        end else if (is_exec) begin
                            ready_n = 1'b1;
                            type_n  = INPUT;
                            param_n = '{Pn1: 8'd0, Pchar: dataIn};
                        end
                    end

                    default: state_n = S_GROUND;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_GROUND;
            acc          <= 8'd0;
            semi         <= 1'b0;
            commandReady <= 1'b0;
            commandType  <= INPUT;
            param        <= '0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            semi         <= semi_n;
            commandReady <= ready_n;
            commandType  <= type_n;
            param        <= param_n;
        end
    end

endmodule

// File: tb/tb_escape_sequence_decoder.sv
// Testbench: tb_escape_sequence_decoder
// Drives directed and random byte streams into escape_sequence_decoder and
// compares every cycle against a reference model that collects each escape
// sequence as a byte string and interprets it once the string is complete.
module tb_escape_sequence_decoder;
    import escape_sequence_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dataValid = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        commandReady;
    CommandsType commandType;
    Param_t      param;
    logic        parserIdle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    escape_sequence_decoder #(
        .PARAM_MAX (8'd255),
        .C1_CSI    (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dataValid    (dataValid),
        .dataIn       (dataIn),
        .commandReady (commandReady),
        .commandType  (commandType),
        .param        (param),
        .parserIdle   (parserIdle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pending holds the unfinished sequence: empty = ground, {ESC} = after ESC,
    // {ESC,'['} followed by the collected parameter/intermediate bytes = CSI.
    logic [7:0]  pending[$];
    logic        m_ready;
    CommandsType m_type;
    logic [7:0]  m_pn1;
    logic [7:0]  m_pchar;

    function automatic bit c0_exec(input logic [7:0] b);
        return (b == 8'h08) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
    endfunction

    task automatic emit(input CommandsType t, input logic [7:0] pn1, input logic [7:0] pchar);
        m_ready = 1'b1;
        m_type  = t;
        m_pn1   = pn1;
        m_pchar = pchar;
    endtask

    task automatic model_reset();
        pending.delete();
        m_ready = 1'b0;
        m_type  = INPUT;
        m_pn1   = 8'd0;
        m_pchar = 8'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit         bad;
        bit         seen_semi;
        int         v;
        logic [7:0] c;
        if (b == 8'h18 || b == 8'h1A) begin
            pending.delete();
        end else if (b == 8'h1B) begin
            pending.delete();
            pending.push_back(8'h1B);
        end else if (b == 8'h7F) begin
            // padding
        end else if (pending.size() == 0) begin
            if ((b >= 8'h20 && b <= 8'h7E) || c0_exec(b)) emit(INPUT, 8'd0, b);
            else if (b == 8'h9B) begin
                pending.push_back(8'h1B);
                pending.push_back(8'h5B);
            end
        end else if (pending.size() == 1) begin
            if (b == 8'h48) begin
                emit(HTS, 8'd0, 8'd0);
                pending.delete();
            end else if (b == 8'h5B) begin
                pending.push_back(b);
            end else begin
                pending.delete();
            end
        end else begin
            if (c0_exec(b)) begin
                emit(INPUT, 8'd0, b);
            end else if (b >= 8'h40 && b <= 8'h7E) begin
                bad = 0;
                seen_semi = 0;
                v = 0;
                for (int i = 2; i < pending.size(); i++) begin
                    c = pending[i];
                    if (c == 8'h3B) seen_semi = 1;
                    else if (c >= 8'h30 && c <= 8'h39) begin
                        if (!seen_semi) begin
                            v = v * 10 + int'(c - 8'h30);
                            if (v > 255) v = 255;
                        end
                    end else bad = 1;
                end
                if (!bad) begin
                    if (b == 8'h67) emit(TBC, 8'(v), 8'd0);
                    else if (b == 8'h49) emit(CHT, (v == 0) ? 8'd1 : 8'(v), 8'd0);
                    else if (b == 8'h5A) emit(CBT, (v == 0) ? 8'd1 : 8'(v), 8'd0);
                end
                pending.delete();
            end else if (b >= 8'h20 && b <= 8'h3F) begin
                pending.push_back(b);
            end
        end
    endtask

    // One clock: apply inputs, let the edge take them, then compare all outputs.
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        rst_n     = r;
        dataValid = v;
        dataIn    = b;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        if (!r) model_reset();
        else if (v) model_byte(b);
        check("ready", commandReady, m_ready);
        check("type",  commandType,  m_type);
        check("pn1",   param.Pn1,    m_pn1);
        check("pchar", param.Pchar,  m_pchar);
        check("idle",  parserIdle,   pending.size() == 0);
    endtask

    task automatic send(input logic [7:0] seq[$]);
        foreach (seq[i]) step(1'b1, seq[i], 1'b1);
    endtask

    // Latched command against hand-computed constants.
    task automatic expect_cmd(input string tag, input CommandsType t,
                              input logic [7:0] pn1, input logic [7:0] pchar);
        check({tag, "_type"},  commandType, t);
        check({tag, "_pn1"},   param.Pn1,   pn1);
        check({tag, "_pchar"}, param.Pchar, pchar);
    endtask

    logic [7:0] seq[$];
    logic [7:0] picks[18] = '{8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h67, 8'h49, 8'h5A, 8'h48,
                              8'h09, 8'h0D, 8'h18, 8'h1A, 8'h7F, 8'h3F, 8'h20, 8'h9B,
                              8'h41, 8'h78};

    initial begin
        model_reset();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("rst_ready", commandReady, 1'b0);
        check("rst_idle",  parserIdle,   1'b1);
        expect_cmd("rst", INPUT, 8'd0, 8'd0);

        seq = '{8'h41};                          send(seq); expect_cmd("t1_A", INPUT, 8'd0, 8'h41);
        step(1'b0, 8'h00, 1'b1);
        check("t1_strobe_drop", commandReady, 1'b0);

        seq = '{8'h1B, 8'h48};                   send(seq); expect_cmd("t2_hts", HTS, 8'd0, 8'd0);
        seq = '{8'h1B, 8'h78};                   send(seq); expect_cmd("t2_escx", HTS, 8'd0, 8'd0);
        check("t2_idle", parserIdle, 1'b1);

        seq = '{8'h1B, 8'h5B, 8'h33, 8'h67};     send(seq); expect_cmd("t3_tbc3", TBC, 8'd3, 8'd0);
        seq = '{8'h1B, 8'h5B, 8'h67};            send(seq); expect_cmd("t3_tbc0", TBC, 8'd0, 8'd0);
        seq = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h37, 8'h67};
        send(seq); expect_cmd("t3_tbc_semi", TBC, 8'd1, 8'd0);

        seq = '{8'h1B, 8'h5B, 8'h49};            send(seq); expect_cmd("t4_cht", CHT, 8'd1, 8'd0);
        seq = '{8'h1B, 8'h5B, 8'h30, 8'h5A};     send(seq); expect_cmd("t4_cbt0", CBT, 8'd1, 8'd0);
        seq = '{8'h1B, 8'h5B, 8'h39, 8'h39, 8'h39, 8'h49};
        send(seq); expect_cmd("t4_sat", CHT, 8'd255, 8'd0);

        seq = '{8'h1B, 8'h5B, 8'h31, 8'h09};     send(seq); expect_cmd("t5_tab", INPUT, 8'd0, 8'h09);
        seq = '{8'h32, 8'h49};                   send(seq); expect_cmd("t5_cht12", CHT, 8'd12, 8'd0);
        seq = '{8'h1B, 8'h5B, 8'h3F, 8'h35, 8'h67};
        send(seq); expect_cmd("t5_priv", CHT, 8'd12, 8'd0);
        seq = '{8'h1B, 8'h5B, 8'h32, 8'h18, 8'h42};
        send(seq); expect_cmd("t5_can", INPUT, 8'd0, 8'h42);

        seq = '{8'h1B, 8'h5B, 8'h34};            send(seq);
        step(1'b1, 8'h41, 1'b0);
        check("t6_rst_ready", commandReady, 1'b0);
        check("t6_rst_idle",  parserIdle,   1'b1);
        expect_cmd("t6_rst", INPUT, 8'd0, 8'd0);
        seq = '{8'h35};                          send(seq); expect_cmd("t6_5", INPUT, 8'd0, 8'h35);
        seq = '{8'h9B, 8'h32, 8'h5A};            send(seq); expect_cmd("t6_c1", CBT, 8'd2, 8'd0);

        for (int n = 0; n < 4000; n++) begin
            logic [7:0] b;
            logic       v;
            logic       r;
            v = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else begin
                b = picks[$urandom_range(0, 17)];
                if (b == 8'h30) b = 8'h30 + 8'($urandom_range(0, 9));
            end
            step(v, b, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
